// File: rtl/gap_pool_sched_pkg.sv
// Shared constants and FSM state encodings for the global-average-pool scheduler.
package gap_pool_sched_pkg;

  localparam int N_ELEM      = 169;   // words per 13x13 channel window
  localparam int DATA_W      = 16;    // FP16 word width
  localparam int ADDR_W      = 18;    // buffer address width
  localparam int CH_W        = 10;    // channel count/index width
  localparam int TIMEOUT_DEF = 1024;  // default max RUN cycles per channel
  localparam int WIN_W       = N_ELEM * DATA_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

endpackage

// File: rtl/gap_pool_sched_fetch.sv
// pool_win_fetch: streams one channel window from the feature buffer.
//   load       : reload the read address with src_base (accepted start)
//   src_base   : feature buffer base address
//   fetch_en   : scheduler is in FETCH; one read is issued per cycle
//   rd_data    : buffer data, valid one cycle after rd_en
//   rd_en/rd_addr : feature buffer read port
//   fetch_done : high in the cycle the last of N_ELEM reads is issued
//   pool_im    : window shift register, element 0 ends in the MSB slice
module pool_win_fetch
  import gap_pool_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] src_base,
  input  logic              fetch_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              fetch_done,
  output logic [WIN_W-1:0]  pool_im
);

  localparam int CNT_W = $clog2(N_ELEM);

  logic [CNT_W-1:0] elem_cnt;
  logic             rd_vld_q;

  assign rd_en      = fetch_en;
  assign fetch_done = fetch_en && (elem_cnt == '0);

  // Channels are contiguous, so the address just keeps counting across
  // channel boundaries; only a new start reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      elem_cnt <= CNT_W'(N_ELEM - 1);
      rd_vld_q <= 1'b0;
      pool_im  <= '0;
    end else begin
      if (load)
        rd_addr <= src_base;
      else if (rd_en)
        rd_addr <= rd_addr + ADDR_W'(1);

      if (fetch_en)
        elem_cnt <= elem_cnt - CNT_W'(1);
      else
        elem_cnt <= CNT_W'(N_ELEM - 1);

      rd_vld_q <= rd_en;
      if (rd_vld_q)
        pool_im <= {pool_im[WIN_W-DATA_W-1:0], rd_data};
    end
  end

endmodule

// File: rtl/gap_pool_sched.sv
// gap_pool_sched: sequences the 13x13 FP16 pool core over all channels.
//   start/channels/src_base/dst_base : launch command, sampled on accepted start
//   busy/done/error                  : status (error is a sticky timeout flag)
//   rd_en/rd_addr/rd_data            : feature buffer read port (1-cycle latency)
//   pool_im/pool_ready/pool_valid/pool_om : pool core interface
//   wr_en/wr_addr/wr_data            : output buffer write port
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing N_ELEM reads for the current channel
// DRAIN   | capturing the last read word
// RUN     | pool_ready high, window frozen, waiting for pool_valid / timeout
// WRITE   | writing the result to dst_base + channel
// GAP     | pool_ready low one extra cycle so the core clears its accumulator
// DONE    | done pulse; busy falls together with done
module gap_pool_sched
  import gap_pool_sched_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CH_W-1:0]   channels,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [WIN_W-1:0]  pool_im,
  output logic              pool_ready,
  input  logic              pool_valid,
  input  logic [DATA_W-1:0] pool_om,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]        state, state_nxt;
  logic [CH_W-1:0]   chan_q;
  logic [CH_W-1:0]   ch_idx;
  logic [ADDR_W-1:0] wr_ptr;
  logic [TMR_W-1:0]  tmr;
  logic              start_acc;
  logic              last_ch;
  logic              fetch_done;
  logic              tmr_tc;

  assign start_acc  = (state == S_IDLE) && start;
  assign last_ch    = (ch_idx == chan_q - CH_W'(1));
  assign tmr_tc     = (tmr == '0);

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign pool_ready = (state == S_RUN);
  assign wr_en      = (state == S_WRITE);
  assign wr_addr    = wr_ptr;

  pool_win_fetch u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_acc),
    .src_base   (src_base),
    .fetch_en   (state == S_FETCH),
    .rd_data    (rd_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .fetch_done (fetch_done),
    .pool_im    (pool_im)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (channels == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (fetch_done) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_RUN;
      S_RUN: begin
        // A valid on the final timer cycle still wins over the timeout.
        if (pool_valid)  state_nxt = S_WRITE;
        else if (tmr_tc) state_nxt = S_DONE;
      end
      S_WRITE: state_nxt = S_GAP;
      S_GAP:   state_nxt = last_ch ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      chan_q  <= '0;
      ch_idx  <= '0;
      wr_ptr  <= '0;
      wr_data <= '0;
      error   <= 1'b0;
      tmr     <= '0;
    end else begin
      state <= state_nxt;

      if (start_acc) begin
        chan_q <= channels;
        ch_idx <= '0;
        wr_ptr <= dst_base;
        error  <= 1'b0;
      end else if (state == S_GAP) begin
        ch_idx <= ch_idx + CH_W'(1);
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end

      if (state != S_RUN)
        tmr <= TMR_W'(TIMEOUT - 1);
      else if (!tmr_tc)
        tmr <= tmr - TMR_W'(1);

      if (state == S_RUN) begin
        if (pool_valid)
          wr_data <= pool_om;
        else if (tmr_tc)
          error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gap_pool_sched.sv
module tb_gap_pool_sched;
  import gap_pool_sched_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CH_W-1:0]   channels;
  logic [ADDR_W-1:0] src_base, dst_base;
  logic              busy, done, error;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [WIN_W-1:0]  pool_im;
  logic              pool_ready, pool_valid;
  logic [DATA_W-1:0] pool_om;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always #5 clk = ~clk;

  gap_pool_sched #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .channels(channels),
    .src_base(src_base), .dst_base(dst_base), .busy(busy), .done(done),
    .error(error), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pool_im(pool_im), .pool_ready(pool_ready), .pool_valid(pool_valid),
    .pool_om(pool_om), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Buffer model: word at address a is 16'h3C00 + a, one cycle after rd_en.
  initial rd_data = '0;
  always @(posedge clk) if (rd_en) rd_data <= 16'h3C00 + rd_addr[15:0];

  // Pool core model: valid on the 5th RUN cycle; om is either a constant or
  // the channel tag (number of results produced since start).
  logic        never_valid = 1'b0, om_tag = 1'b0, spur_valid = 1'b0;
  logic [7:0]  run_cnt = '0;
  logic [15:0] tag_cnt = '0;
  always @(posedge clk) begin
    run_cnt <= pool_ready ? run_cnt + 8'd1 : 8'd0;
    if (!busy) tag_cnt <= '0;
    else if (pool_ready && pool_valid) tag_cnt <= tag_cnt + 16'd1;
  end
  assign pool_valid = spur_valid | (pool_ready && !never_valid && run_cnt == 8'd4);
  assign pool_om    = om_tag ? tag_cnt : 16'h3A5A;

  // Monitor, sampling on the falling edge.
  logic clr_mon = 1'b0;
  int cyc = 0, rd_cnt, first_rd, last_rd, first_rd_cyc, contig_err, wr_cnt;
  int overlap_err, im_err, done_cyc, st_cyc, busy_cnt, ready_cnt;
  int gap_n, gap_min, gap_max, fall_cyc;
  logic [31:0] wr_addr_log [0:7];
  logic [31:0] wr_data_log [0:7];
  logic prev_ready = 1'b0, prev_rd = 1'b0, had_fall;
  logic [WIN_W-1:0] prev_im;

  always @(negedge clk) begin
    cyc++;
    if (clr_mon) begin
      rd_cnt = 0; first_rd = -1; last_rd = -1; first_rd_cyc = -1; contig_err = 0;
      wr_cnt = 0; overlap_err = 0; im_err = 0; done_cyc = -1; st_cyc = -1;
      busy_cnt = 0; ready_cnt = 0; gap_n = 0; gap_min = 999; gap_max = -1;
      had_fall = 1'b0; fall_cyc = 0;
    end else begin
      if (start && !busy) st_cyc = cyc;
      if (busy) busy_cnt++;
      if (pool_ready) ready_cnt++;
      if (rd_en) begin
        if (rd_cnt == 0) begin first_rd = int'(rd_addr); first_rd_cyc = cyc; end
        else if (int'(rd_addr) != last_rd + 1) contig_err++;
        last_rd = int'(rd_addr);
        rd_cnt++;
      end
      if (wr_en) begin
        if (wr_cnt < 8) begin
          wr_addr_log[wr_cnt] = 32'(wr_addr);
          wr_data_log[wr_cnt] = 32'(wr_data);
        end
        wr_cnt++;
      end
      if (rd_en && wr_en) overlap_err++;
      if (pool_ready && prev_ready && pool_im !== prev_im) im_err++;
      if (prev_ready && !pool_ready) begin had_fall = 1'b1; fall_cyc = cyc; end
      if (rd_en && !prev_rd && had_fall) begin
        gap_n++;
        if (cyc - fall_cyc < gap_min) gap_min = cyc - fall_cyc;
        if (cyc - fall_cyc > gap_max) gap_max = cyc - fall_cyc;
        had_fall = 1'b0;
      end
      if (done) done_cyc = cyc;
    end
    prev_ready = pool_ready;
    prev_rd    = rd_en;
    prev_im    = pool_im;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    tick(); clr_mon = 1'b1; tick(); clr_mon = 1'b0;
  endtask

  task automatic do_start(input int ch, input int src, input int dst);
    tick();
    start = 1'b1; channels = CH_W'(ch); src_base = ADDR_W'(src); dst_base = ADDR_W'(dst);
    tick();
    start = 1'b0; channels = 10'd7; src_base = 18'h2AAAA; dst_base = 18'h15555;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic check_three(input string tag);
    chk({tag, "_rd_cnt"}, rd_cnt, 507);
    chk({tag, "_rd_first"}, first_rd, 100);
    chk({tag, "_rd_last"}, last_rd, 606);
    chk({tag, "_contig"}, contig_err, 0);
    chk({tag, "_wr_cnt"}, wr_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_wr_addr"}, wr_addr_log[i], 32'(5000 + i));
      chk({tag, "_wr_data"}, wr_data_log[i], 32'(i));
    end
    chk({tag, "_gap_n"}, gap_n, 2);
    chk({tag, "_gap_min"}, gap_min, 2);
    chk({tag, "_gap_max"}, gap_max, 2);
    chk({tag, "_overlap"}, overlap_err, 0);
    chk({tag, "_im_stable"}, im_err, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst_n = 1'b0; start = 1'b0; channels = '0; src_base = '0; dst_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_ready", pool_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pool_im", (pool_im == '0), 1);
    tick(); rst_n = 1'b1;

    // Single channel, constant result.
    clear_mon();
    do_start(1, 0, 300);
    wait_done(2000, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_rd_cnt", rd_cnt, 169);
    chk("t1_rd_first", first_rd, 0);
    chk("t1_rd_last", last_rd, 168);
    chk("t1_contig", contig_err, 0);
    chk("t1_wr_cnt", wr_cnt, 1);
    chk("t1_wr_addr", wr_addr_log[0], 300);
    chk("t1_wr_data", wr_data_log[0], 16'h3A5A);
    chk("t1_latency", done_cyc - first_rd_cyc, 177);
    chk("t1_im_lsb", pool_im[15:0], 16'h3CA8);
    chk("t1_im_msb", pool_im[WIN_W-1 -: 16], 16'h3C00);
    chk("t1_error", error, 0);
    chk("t1_busy_after", busy, 0);

    // Three channels with channel-tag results.
    om_tag = 1'b1;
    clear_mon();
    do_start(3, 100, 5000);
    wait_done(3000, ok);
    chk("t2_done_seen", ok, 1);
    check_three("t2");

    // Zero channels.
    clear_mon();
    do_start(0, 0, 0);
    wait_done(10, ok);
    chk("t3_done_seen", ok, 1);
    chk("t3_done_lat", done_cyc - st_cyc, 1);
    chk("t3_busy_cycles", busy_cnt, 1);
    chk("t3_rd_cnt", rd_cnt, 0);
    chk("t3_wr_cnt", wr_cnt, 0);

    // Timeout, then the next start clears error.
    never_valid = 1'b1;
    clear_mon();
    do_start(2, 0, 40);
    wait_done(1000, ok);
    chk("t4_done_seen", ok, 1);
    chk("t4_error", error, 1);
    chk("t4_run_cycles", ready_cnt, 16);
    chk("t4_wr_cnt", wr_cnt, 0);
    chk("t4_rd_cnt", rd_cnt, 169);
    never_valid = 1'b0;
    tick();
    chk("t4_error_sticky", error, 1);
    clear_mon();
    do_start(0, 0, 0);
    wait_done(10, ok);
    chk("t4_error_cleared", error, 0);

    // Reset in the middle of channel 1's RUN.
    clear_mon();
    do_start(3, 0, 700);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pool_ready && wr_cnt == 1) begin ok = 1'b1; break; end
    end
    chk("t5_reached_run1", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ready", pool_ready, 0);
    chk("t5_rd_addr", rd_addr, 0);
    chk("t5_wr_data", wr_data, 0);
    chk("t5_pool_im", (pool_im == '0), 1);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t5_no_more_writes", wr_cnt, 1);
    clear_mon();
    do_start(2, 0, 10);
    wait_done(2000, ok);
    chk("t5_restart_done", ok, 1);
    chk("t5_restart_first_rd", first_rd, 0);
    chk("t5_restart_wr_cnt", wr_cnt, 2);
    chk("t5_restart_wr0", wr_data_log[0], 0);
    chk("t5_restart_addr1", wr_addr_log[1], 11);
    chk("t5_restart_wr1", wr_data_log[1], 1);

    // Start and pool_valid during FETCH are ignored.
    clear_mon();
    do_start(3, 100, 5000);
    repeat (20) tick();
    start = 1'b1; channels = 10'd1; src_base = '0; dst_base = '0; spur_valid = 1'b1;
    tick();
    start = 1'b0; spur_valid = 1'b0;
    wait_done(3000, ok);
    chk("t6_done_seen", ok, 1);
    check_three("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gap_pool_sched.md
Name: gap_pool_sched

Overview:
Scheduler that sequences the 13x13 FP16 global-average-pool core across all channels of the final feature map. Per channel it streams 169 FP16 words from the feature buffer into a 169x16 window register, then holds the pool core's enable with a stable window until the core reports valid. It then writes the 16-bit result to the output buffer and moves to the next channel. It sits between the top-level command decoder, the on-chip feature/output buffers and the pool_13x13 datapath.

Parameters:
N_ELEM, 169, words per channel window (13x13)
DATA_W, 16, FP16 word width
ADDR_W, 18, buffer address width (covers 1000x169 words)
CH_W, 10, width of channel count/index
TIMEOUT, 1024, max cycles to wait for pool_valid per channel

Ports:
clk  in  1  system clock
rst_n  in  1  async active-low reset
start  in  1  one-cycle launch pulse, ignored while busy
channels  in  CH_W  channel count, sampled on start
src_base  in  ADDR_W  feature buffer base, sampled on start
dst_base  in  ADDR_W  output buffer base, sampled on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
error  out  1  sticky timeout flag, cleared by next accepted start
rd_en  out  1  feature buffer read strobe
rd_addr  out  ADDR_W  feature buffer read address
rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
pool_im  out  N_ELEM*DATA_W  window to pool core
pool_ready  out  1  pool core enable (level)
pool_valid  in  1  pool core result valid
pool_om  in  DATA_W  pool core result
wr_en  out  1  output buffer write strobe
wr_addr  out  ADDR_W  output buffer write address
wr_data  out  DATA_W  output buffer write data

Behaviour:
- Reset (async, rst_n low): state IDLE; busy, done, error, rd_en, pool_ready and wr_en are 0; rd_addr, wr_addr, wr_data and pool_im are 0; counters are 0. Reset mid-operation abandons the channel with no partial write.
- Layout: channel c, element k is at src_base + c*N_ELEM + k. The result for c goes to dst_base + c. Address arithmetic wraps modulo 2^ADDR_W.
- Window packing: each rd_data shifts in at the LSB (pool_im <= {pool_im[N_ELEM*DATA_W-DATA_W-1:0], rd_data}). Element 0 ends in the MSB slice and element 168 in bits [15:0].
- IDLE: on start, latch the inputs, clear error, set busy. If channels==0, go to DONE with no reads; otherwise go to FETCH.
- FETCH: rd_en=1 for exactly N_ELEM consecutive cycles with an incrementing address, then go to DRAIN.
- DRAIN: capture the last word (1 cycle), then go to RUN.
- RUN: pool_ready=1 and pool_im is frozen. On pool_valid, register pool_om into wr_data and go to WRITE. If TIMEOUT cycles elapse without pool_valid, set error, drop pool_ready and go to DONE.
- pool_valid outside RUN is ignored.
- WRITE: wr_en=1 for 1 cycle at dst_base+c, with pool_ready=0. Then go to GAP.
- GAP: pool_ready stays 0 for 1 cycle so the core clears its accumulator. If c==channels-1 go to DONE; otherwise increment c and go to FETCH.
- DONE: done=1 for 1 cycle, busy drops in the same cycle, then go to IDLE.
- Latency per channel: 169 (FETCH) + 1 (DRAIN) + L_pool (RUN cycles including the valid cycle) + 1 (WRITE) + 1 (GAP).
- start while busy is ignored. Inputs that change while busy have no effect.
- pool_ready never goes high while pool_im is changing. rd_en and wr_en are never high in the same cycle.

Decomposition:
- Shared package: N_ELEM, DATA_W, the state enum (IDLE, FETCH, DRAIN, RUN, WRITE, GAP, DONE), TIMEOUT default.
- One natural sub-module, pool_win_fetch: read address counter, 1-cycle data-valid pipe and the 169x16 shift register. It reports fetch_done to the scheduler FSM.

Test Plan:
- Single channel: src_base=0, channels=1, memory word k = 16'h3C00+k, pool model with 5-cycle latency and om=16'h3A5A -> 169 reads at 0..168; pool_im[15:0]=16'h3CA8 and MSB slice=16'h3C00; one write of 16'h3A5A at dst_base; done 177 cycles after the first rd_en.
- Three channels: src_base=100, dst_base=5000, model om = channel tag -> reads 100..606 contiguous; writes at 5000/5001/5002 with tags 0/1/2; pool_ready low exactly 2 cycles (WRITE, GAP) between runs.
- channels=0 -> no rd_en, no wr_en; done 1 cycle after start; busy high for 1 cycle.
- Timeout: model never asserts valid, TIMEOUT=16 -> error=1 and done after 16 RUN cycles; no write. The next start clears error.
- Reset mid-RUN of channel 1 of 3 -> all outputs 0 immediately; no further writes. A new start executes cleanly from channel 0.
- start pulsed during FETCH and a spurious pool_valid during FETCH -> both ignored; address sequence and results identical to the clean run.
